vga_scan_generator: RTL and testbench

//   Produces VGA raster timing and the per-pixel inputs consumed by the 4-bit canvas renderer.

---
 rtl/vga_scan_generator.sv | 179 +++++++++++++++++
 tb/tb_vga_scan_generator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_generator.sv
// VGA raster timing generator for the Game-of-Life canvas renderer.
// Scans the raster, maps every visible pixel to a grid cell, issues the cell
// read to the canvas RAM and aligns the returned alive bit with the sync and
// cursor flags so that the renderer sees all outputs change on the same clk edge.
module vga_scan_generator #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CELL_SHIFT  = 4,
  parameter int GRID_W      = H_ACTIVE >> CELL_SHIFT,
  parameter int GRID_H      = V_ACTIVE >> CELL_SHIFT,
  parameter int ADDR_W      = 11,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixelTick,
  input  logic [5:0]        cursorX,
  input  logic [4:0]        cursorY,
  output logic [ADDR_W-1:0] cellAddr,
  input  logic              cellData,
  output logic              hsync,
  output logic              vsync,
  output logic              pixelActive,
  output logic              isCursor,
  output logic              pixelState,
  output logic              frameStart
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  // row * GRID_W built from shifted copies of row, one per set bit of GRID_W.
  // The operand is already ADDR_W wide, so no partial product is truncated
  // for any address the visible area can produce.
  function automatic logic [ADDR_W-1:0] times_grid_w(input logic [ADDR_W-1:0] r);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 31; i++) begin
      if (((GRID_W >> i) & 1) == 1) acc = acc + (r << i);
    end
    return acc;
  endfunction

  // Raster position
  logic [H_W-1:0]    hCount_q, hCount_d;
  logic [V_W-1:0]    vCount_q, vCount_d;

  // Stage 0 values derived from the current raster position
  logic [H_W-1:0]    col0;
  logic [V_W-1:0]    row0;
  logic              active0, hs0, vs0, cur0, wrap0;
  logic [ADDR_W-1:0] addr0;

  // Stage 0 registers: RAM address plus the flags waiting for the RAM data
  logic [ADDR_W-1:0] cellAddr_q;
  logic              hs0_q, vs0_q, act0_q, cur0_q;

  // Tick delay line that marks the clk on which the RAM data is valid
  logic [RAM_LATENCY:1] tick_sr_q;
  logic                 cap_stb;

  // Output registers
  logic hsync_q, vsync_q, pixelActive_q, isCursor_q, pixelState_q, frameStart_q;

  // Next raster position: step one pixel per tick, wrapping line then frame
  always_comb begin
    hCount_d = hCount_q;
    vCount_d = vCount_q;
    if (pixelTick) begin
      if (hCount_q == H_W'(H_TOTAL - 1)) begin
        hCount_d = '0;
        if (vCount_q == V_W'(V_TOTAL - 1)) vCount_d = '0;
        else                               vCount_d = vCount_q + V_W'(1);
      end else begin
        hCount_d = hCount_q + H_W'(1);
      end
    end
  end

  // Raster counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      hCount_q <= '0;
      vCount_q <= '0;
    end else begin
      hCount_q <= hCount_d;
      vCount_q <= vCount_d;
    end
  end

  // Stage 0 decode: visibility, cell address, sync windows and cursor hit
  always_comb begin
    col0    = hCount_q >> CELL_SHIFT;
    row0    = vCount_q >> CELL_SHIFT;
    active0 = (hCount_q < H_W'(H_ACTIVE)) && (vCount_q < V_W'(V_ACTIVE));
    addr0   = '0;
    if (active0) addr0 = times_grid_w(ADDR_W'(row0)) + ADDR_W'(col0);
    hs0     = !((hCount_q >= H_W'(HS_START)) && (hCount_q <= H_W'(HS_END)));
    vs0     = !((vCount_q >= V_W'(VS_START)) && (vCount_q <= V_W'(VS_END)));
    // An off-grid cursor never matches, even where the column or row bits alias
    cur0    = active0
              && (int'(cursorX) < GRID_W) && (int'(cursorY) < GRID_H)
              && (int'(col0) == int'(cursorX)) && (int'(row0) == int'(cursorY));
    wrap0   = (hCount_q == H_W'(H_TOTAL - 1)) && (vCount_q == V_W'(V_TOTAL - 1));
  end

  // Stage 0 register: launch the RAM read and park the flags on each tick
  always_ff @(posedge clk) begin
    if (reset) begin
      cellAddr_q <= '0;
      hs0_q      <= 1'b1;
      vs0_q      <= 1'b1;
      act0_q     <= 1'b0;
      cur0_q     <= 1'b0;
    end else if (pixelTick) begin
      cellAddr_q <= addr0;
      hs0_q      <= hs0;
      vs0_q      <= vs0;
      act0_q     <= active0;
      cur0_q     <= cur0;
    end
  end

  // Delay the tick by the RAM latency so capture lands when cellData is valid
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_sr_q <= '0;
    end else begin
      tick_sr_q[1] <= pixelTick;
      for (int i = 2; i <= RAM_LATENCY; i++) tick_sr_q[i] <= tick_sr_q[i-1];
    end
  end

  assign cap_stb = tick_sr_q[RAM_LATENCY];

  // Output stage: flags and the alive bit update together; blanked pixels read as dead
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      pixelActive_q <= 1'b0;
      isCursor_q    <= 1'b0;
      pixelState_q  <= 1'b0;
    end else if (cap_stb) begin
      hsync_q       <= hs0_q;
      vsync_q       <= vs0_q;
      pixelActive_q <= act0_q;
      isCursor_q    <= cur0_q;
      pixelState_q  <= act0_q & cellData;
    end
  end

  // Single-clk frame marker on the tick that wraps the raster back to (0,0)
  always_ff @(posedge clk) begin
    if (reset) frameStart_q <= 1'b0;
    else       frameStart_q <= pixelTick & wrap0;
  end

  assign cellAddr    = cellAddr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign pixelActive = pixelActive_q;
  assign isCursor    = isCursor_q;
  assign pixelState  = pixelState_q;
  assign frameStart  = frameStart_q;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator. Two instances share the stimulus: one built
// for a 1-clk RAM and one for a 2-clk RAM. The raster is shrunk (92x52 total,
// 80x48 visible, 5x3 cells of 16x16) so whole frames fit in a short run.
module tb_vga_scan_generator;

  localparam int H_ACT = 80, H_FP = 2, H_SY = 8, H_BP = 2;
  localparam int V_ACT = 48, V_FP = 1, V_SY = 2, V_BP = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int GW = H_ACT / 16;
  localparam int GH = V_ACT / 16;
  localparam int AW = 11;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          pixelTick;
  logic [5:0]    cursorX;
  logic [4:0]    cursorY;
  logic [AW-1:0] cellAddr1, cellAddr2;
  logic          cellData1, cellData2;
  logic          hsync1, vsync1, pixelActive1, isCursor1, pixelState1, frameStart1;
  logic          hsync2, vsync2, pixelActive2, isCursor2, pixelState2, frameStart2;
  logic [AW-1:0] ram_target;
  logic          rd2_q;

  vga_scan_generator #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .CELL_SHIFT(4), .GRID_W(GW), .GRID_H(GH), .ADDR_W(AW), .RAM_LATENCY(1)
  ) dut1 (
    .clk(clk), .reset(reset), .pixelTick(pixelTick),
    .cursorX(cursorX), .cursorY(cursorY),
    .cellAddr(cellAddr1), .cellData(cellData1),
    .hsync(hsync1), .vsync(vsync1), .pixelActive(pixelActive1),
    .isCursor(isCursor1), .pixelState(pixelState1), .frameStart(frameStart1)
  );

  vga_scan_generator #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .CELL_SHIFT(4), .GRID_W(GW), .GRID_H(GH), .ADDR_W(AW), .RAM_LATENCY(2)
  ) dut2 (
    .clk(clk), .reset(reset), .pixelTick(pixelTick),
    .cursorX(cursorX), .cursorY(cursorY),
    .cellAddr(cellAddr2), .cellData(cellData2),
    .hsync(hsync2), .vsync(vsync2), .pixelActive(pixelActive2),
    .isCursor(isCursor2), .pixelState(pixelState2), .frameStart(frameStart2)
  );

  // Canvas RAM models holding a single live cell at ram_target.
  // Latency 1: data settles within the clk after the address changes.
  // Latency 2: one extra register stage.
  assign cellData1 = (cellAddr1 == ram_target);
  always @(posedge clk) rd2_q <= (cellAddr2 == ram_target);
  assign cellData2 = rd2_q;

  // ---------------- scoreboard state ----------------
  logic [4:0] exp_q1[$];
  logic [4:0] exp_q2[$];
  int n_tests, n_fail;
  int m_h, m_v, cur_h, cur_v;
  int tick_idx;
  int fs_cnt, fs_first, fs_second;
  int hs_cnt, hs_first, vs_lines, vs_first;
  int cur_cnt, st_cnt, last_addr_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s near pixel (%0d,%0d): got %0d, expected %0d", tag, cur_h, cur_v, obs, exp);
    end
  endtask

  // Reference pixel: {addr[10:0], hsync, vsync, active, cursor, alive}
  function automatic logic [15:0] model_pixel(input int h, input int v, input int cx,
                                              input int cy, input int tgt);
    logic act, hs, vs, cur, st;
    int   addr;
    act  = (h < H_ACT) && (v < V_ACT);
    addr = act ? (v / 16) * GW + (h / 16) : 0;
    hs   = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SY));
    vs   = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SY));
    cur  = act && ((h / 16) == cx) && ((v / 16) == cy);
    st   = act && (addr == tgt);
    return {addr[10:0], hs, vs, act, cur, st};
  endfunction

  // ---------------- driver: one pixel tick, 4 clks long ----------------
  task automatic tick_once();
    logic [15:0] m;
    logic [4:0]  e;
    logic [4:0]  obs;
    logic        fs_e;
    int          ph, pv;
    ph = m_h;
    pv = m_v;
    cur_h = ph;
    cur_v = pv;
    m = model_pixel(ph, pv, int'(cursorX), int'(cursorY), int'(ram_target));
    exp_q1.push_back(m[4:0]);
    exp_q2.push_back(m[4:0]);
    fs_e = (ph == H_TOT - 1) && (pv == V_TOT - 1);
    pixelTick = 1'b1;
    @(negedge clk);
    pixelTick = 1'b0;
    check("addr1", cellAddr1, m[15:5]);
    check("addr2", cellAddr2, m[15:5]);
    check("fs1", frameStart1, fs_e);
    check("fs2", frameStart2, fs_e);
    if (cellAddr1 == AW'(GW * GH - 1)) last_addr_cnt++;
    if (frameStart1) begin
      fs_cnt++;
      if (fs_cnt == 1) fs_first = tick_idx;
      else             fs_second = tick_idx;
    end
    @(negedge clk);
    check("fs1_width", frameStart1, 0);
    @(negedge clk);
    if (exp_q1.size() != 0) begin
      e = exp_q1.pop_front();
      obs = {hsync1, vsync1, pixelActive1, isCursor1, pixelState1};
      check("pix1", obs, e);
    end
    if (exp_q2.size() != 0) begin
      e = exp_q2.pop_front();
      obs = {hsync2, vsync2, pixelActive2, isCursor2, pixelState2};
      check("pix2", obs, e);
    end
    if (isCursor1)   cur_cnt++;
    if (pixelState1) st_cnt++;
    if (!hsync1) begin
      if (hs_cnt == 0) hs_first = ph;
      hs_cnt++;
    end
    if (ph == H_TOT - 1) begin
      check("hs_len", hs_cnt, H_SY);
      check("hs_start", hs_first, H_ACT + H_FP);
      hs_cnt = 0;
      hs_first = -1;
    end
    if ((ph == 0) && !vsync1) begin
      if (vs_lines == 0) vs_first = pv;
      vs_lines++;
    end
    if ((ph == H_TOT - 1) && (pv == V_TOT - 1)) begin
      check("vs_lines", vs_lines, V_SY);
      check("vs_first", vs_first, V_ACT + V_FP);
      vs_lines = 0;
      vs_first = -1;
    end
    @(negedge clk);
    if (m_h == H_TOT - 1) begin
      m_h = 0;
      m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    tick_idx++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr1"}, cellAddr1, 0);
    check({tag, "_addr2"}, cellAddr2, 0);
    check({tag, "_out1"}, {hsync1, vsync1, pixelActive1, isCursor1, pixelState1, frameStart1}, 6'b110000);
    check({tag, "_out2"}, {hsync2, vsync2, pixelActive2, isCursor2, pixelState2, frameStart2}, 6'b110000);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded its time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    n_tests = 0; n_fail = 0;
    m_h = 0; m_v = 0; cur_h = 0; cur_v = 0; tick_idx = 0;
    fs_cnt = 0; fs_first = -1; fs_second = -1;
    hs_cnt = 0; hs_first = -1; vs_lines = 0; vs_first = -1;
    cur_cnt = 0; st_cnt = 0; last_addr_cnt = 0;
    reset = 1'b1; pixelTick = 1'b0;
    cursorX = 6'd0; cursorY = 5'd0; ram_target = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Frame 1: live cell at row 1 col 1, cursor on the last cell
    ram_target = AW'(GW + 1);
    cursorX = 6'(GW - 1);
    cursorY = 5'(GH - 1);
    for (int t = 0; t < FRAME; t++) tick_once();
    check("cursor_pixels", cur_cnt, 256);
    check("alive_pixels", st_cnt, 256);
    check("last_addr_pixels", last_addr_cnt, 256);

    // Frame 2: live cell is the last cell; off-grid cursors, then random moves
    ram_target = AW'(GW * GH - 1);
    cur_cnt = 0;
    cursorX = 6'd45;
    cursorY = 5'd1;
    for (int t = 0; t < FRAME / 3; t++) tick_once();
    check("cursor_x_off_grid", cur_cnt, 0);
    cur_cnt = 0;
    cursorX = 6'd2;
    cursorY = 5'(GH);
    for (int t = 0; t < FRAME / 3; t++) tick_once();
    check("cursor_y_off_grid", cur_cnt, 0);
    for (int t = 2 * (FRAME / 3); t < FRAME; t++) begin
      if ((t % 7) == 0) begin
        cursorX = 6'($urandom_range(0, GW));
        cursorY = 5'($urandom_range(0, GH));
      end
      tick_once();
    end
    check("frame_pulses", fs_cnt, 2);
    check("first_pulse_tick", fs_first, FRAME - 1);
    check("pulse_spacing", fs_second - fs_first, FRAME);

    // Frame 3: reset inside both sync pulses, together with a tick
    cursorX = 6'd0;
    cursorY = 5'd0;
    while (!((m_h == H_ACT + H_FP + 4) && (m_v == V_ACT + V_FP + 1))) tick_once();
    tick_once();
    check("pre_reset_sync_low", {hsync1, vsync1, hsync2, vsync2}, 4'b0000);
    reset = 1'b1;
    pixelTick = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    pixelTick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_h = 0; m_v = 0;
    hs_cnt = 0; hs_first = -1; vs_lines = 0; vs_first = -1;
    exp_q1.delete();
    exp_q2.delete();
    for (int t = 0; t < 2 * H_TOT; t++) tick_once();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
